// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module   : counter
// Brief    : WIDTH-bit binary up/down counter. It steps once per rising clk
//            edge and wraps modulo 2**WIDTH. Reset is asynchronous.
// Revision : 1.0 - initial release
// ============================================================================
module counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;

  // Carry and borrow fall off the top bit, so both directions wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (up_down) begin
      r_count <= r_count + c_one;
    end else begin
      r_count <= r_count - c_one;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter
// Brief    : Directed bench for counter at WIDTH=2 and WIDTH=4. Expected
//            values come from hand-computed tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter;

  logic       clk = 1'b0;
  logic       rst2, ud2, rst4, ud4;
  logic [1:0] cnt2;
  logic [3:0] cnt4;

  int checks = 0;
  int errors = 0;

  logic [1:0] down2 [15];
  logic [1:0] up2   [15];
  logic [3:0] down4 [17];

  always #5 clk = ~clk;

  counter #(.WIDTH(2)) dut2 (
    .clk     (clk),
    .reset   (rst2),
    .up_down (ud2),
    .count   (cnt2)
  );

  counter #(.WIDTH(4)) dut4 (
    .clk     (clk),
    .reset   (rst4),
    .up_down (ud4),
    .count   (cnt4)
  );

  task automatic chk(input string tag, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic at(input time t);
    if (t > $time) #(t - $time);
  endtask

  initial begin
    down2 = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0,
              2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
    up2   = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
              2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    down4 = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
              4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1, 4'd0, 4'd15};

    rst2 = 1'b1; ud2 = 1'b1;
    rst4 = 1'b1; ud4 = 1'b1;

    // Reset held across edges 5 and 15 while up_down toggles.
    at(1);
    chk("reset2_init", {2'b00, cnt2}, 4'd0);
    chk("reset4_init", cnt4, 4'd0);
    at(6);
    chk("reset2_edge5", {2'b00, cnt2}, 4'd0);
    at(10); ud2 = 1'b0; ud4 = 1'b0;
    at(16);
    chk("reset2_edge15", {2'b00, cnt2}, 4'd0);
    chk("reset4_edge15", cnt4, 4'd0);

    // Release with down: 3,2,1,0,3,... from edge 25.
    at(20); rst2 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      at(26 + 10 * i);
      chk("down2", {2'b00, cnt2}, {2'b00, down2[i]});
    end

    // Turn around to up with no penalty; wraps 3->0.
    at(170); ud2 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      at(176 + 10 * i);
      chk("up2", {2'b00, cnt2}, {2'b00, up2[i]});
    end

    // Asynchronous reset between edges, held over several edges.
    at(320); rst2 = 1'b1;
    at(321); chk("async_rst2", {2'b00, cnt2}, 4'd0);
    at(326); chk("rst2_hold325", {2'b00, cnt2}, 4'd0);
    at(336); chk("rst2_hold335", {2'b00, cnt2}, 4'd0);
    at(340); ud2 = 1'b0;
    at(346); chk("rst2_hold345", {2'b00, cnt2}, 4'd0);
    chk("rst4_still_held", cnt4, 4'd0);

    // First edge after release steps down from 0.
    at(350); rst2 = 1'b0;
    at(356); chk("release_down2", {2'b00, cnt2}, 4'd3);
    at(360); ud2 = 1'b1;
    at(366); chk("upwrap2", {2'b00, cnt2}, 4'd0);
    at(376); chk("up2_after_wrap", {2'b00, cnt2}, 4'd1);

    // Short mid-cycle reset pulses, then step per direction.
    at(378); rst2 = 1'b1;
    at(379); chk("pulse_clear_up", {2'b00, cnt2}, 4'd0);
    at(382); rst2 = 1'b0;
    at(386); chk("pulse_step_up", {2'b00, cnt2}, 4'd1);
    at(388); ud2 = 1'b0; rst2 = 1'b1;
    at(389); chk("pulse_clear_down", {2'b00, cnt2}, 4'd0);
    at(392); rst2 = 1'b0;
    at(396); chk("pulse_step_down", {2'b00, cnt2}, 4'd3);

    // WIDTH=4: down from reset through 0->15, then turn around and wrap up.
    at(400); rst4 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      at(406 + 10 * i);
      chk("down4", cnt4, down4[i]);
    end
    at(570); ud4 = 1'b1;
    at(576); chk("upwrap4", cnt4, 4'd0);
    at(586); chk("up4_1", cnt4, 4'd1);
    at(596); chk("up4_2", cnt4, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
